// File: rtl/cmp_pkg.sv
// Shared constants and state encoding for the max-scan controller.
package cmp_pkg;

  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/mag_compare.sv
// Unsigned magnitude comparator: EQ when A==B, GT when A>B.
module mag_compare #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         EQ,
  output logic         GT
);

  assign EQ = (A == B);
  assign GT = (A > B);

endmodule

// File: rtl/max_scan_ctrl.sv
// Buffers a set of words, then scans it one compare per cycle for the
// largest value and its first arrival index.
//   state     | meaning
//   ST_LOAD   | accepting words into the buffer
//   ST_SCAN   | one buffered word compared against the running max per cycle
//   ST_RESULT | result held until the consumer takes it
module max_scan_ctrl
  import cmp_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [N-1:0]             IN_DATA,
  input  logic                     IN_LAST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [N-1:0]             MAX_DATA,
  output logic [$clog2(DEPTH)-1:0] MAX_IDX,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] i_q, i_d;
  logic [N-1:0]  max_q, max_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   count_q, count_d;
  logic [N-1:0]  buf_q [DEPTH];

  logic          accept;
  logic [N-1:0]  cmp_a;
  logic          cmp_eq, cmp_gt;

  assign accept = (state_q == ST_LOAD) && IN_VALID;
  assign cmp_a  = buf_q[i_q];

  mag_compare #(.N(N)) u_cmp (
    .A  (cmp_a),
    .B  (max_q),
    .EQ (cmp_eq),
    .GT (cmp_gt)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    i_d      = i_q;
    max_d    = max_q;
    idx_d    = idx_q;
    count_d  = count_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (IN_LAST || (wr_ptr_q == AW'(DEPTH - 1))) begin
            count_d = {1'b0, wr_ptr_q} + (AW+1)'(1);
            // buf[0] is still being written when the set has one word
            max_d   = (wr_ptr_q == '0) ? IN_DATA : buf_q[0];
            idx_d   = '0;
            i_d     = AW'(1);
            state_d = (wr_ptr_q == '0) ? ST_RESULT : ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        // strictly greater only, so ties keep the earlier index
        if (cmp_gt && !cmp_eq) begin
          max_d = cmp_a;
          idx_d = i_q;
        end
        if ({1'b0, i_q} == (count_q - (AW+1)'(1))) state_d = ST_RESULT;
        else                                       i_d     = i_q + AW'(1);
      end
      ST_RESULT: begin
        if (OUT_READY) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
      i_q      <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      i_q      <= i_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) buf_q[wr_ptr_q] <= IN_DATA;
  end

  assign IN_READY  = (state_q == ST_LOAD);
  assign OUT_VALID = (state_q == ST_RESULT);
  assign BUSY      = (state_q != ST_LOAD);
  assign MAX_DATA  = max_q;
  assign MAX_IDX   = idx_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Directed bench for max_scan_ctrl: hand-computed sets, latency, hold and reset.
module tb_max_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] IN_DATA;
  logic       IN_LAST;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] MAX_DATA;
  logic [2:0] MAX_IDX;
  logic [3:0] COUNT;
  logic       BUSY;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         lat;
  logic [7:0] vec [8];

  max_scan_ctrl #(.N(8), .DEPTH(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_LAST   (IN_LAST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .MAX_DATA  (MAX_DATA),
    .MAX_IDX   (MAX_IDX),
    .COUNT     (COUNT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Feeds vec[0..n-1]; lat counts edges from the last accepting edge until OUT_VALID.
  task automatic load_set(input int n, input bit use_last, input bit wait_res);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_DATA  = vec[k];
      IN_LAST  = use_last && (k == n - 1);
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    chk("in_ready_low_after_last", {31'd0, IN_READY}, 32'd0);
    lat = 1;
    if (wait_res) begin
      while (!OUT_VALID && lat < 40) begin
        @(posedge CLK);
        #1;
        lat++;
      end
    end
  endtask

  task automatic consume();
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    chk("out_valid_drop", {31'd0, OUT_VALID}, 32'd0);
    chk("in_ready_back",  {31'd0, IN_READY},  32'd1);
  endtask

  initial begin
    RST_N     = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b0;
    #2;
    chk("rst_in_ready",  {31'd0, IN_READY},  32'd1);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_busy",      {31'd0, BUSY},      32'd0);
    chk("rst_count",     {28'd0, COUNT},     32'd0);
    chk("rst_max",       {24'd0, MAX_DATA},  32'd0);
    chk("rst_idx",       {29'd0, MAX_IDX},   32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // tie on 9: first occurrence wins
    vec[0] = 8'd3; vec[1] = 8'd9; vec[2] = 8'd4; vec[3] = 8'd9;
    load_set(4, 1'b1, 1'b1);
    chk("s1_latency", lat, 32'd4);
    chk("s1_max",   {24'd0, MAX_DATA}, 32'd9);
    chk("s1_idx",   {29'd0, MAX_IDX},  32'd1);
    chk("s1_count", {28'd0, COUNT},    32'd4);
    chk("s1_busy",  {31'd0, BUSY},     32'd1);
    consume();

    vec[0] = 8'h55;
    load_set(1, 1'b1, 1'b1);
    chk("s2_latency", lat, 32'd1);
    chk("s2_max",   {24'd0, MAX_DATA}, 32'h55);
    chk("s2_idx",   {29'd0, MAX_IDX},  32'd0);
    chk("s2_count", {28'd0, COUNT},    32'd1);
    consume();

    for (int k = 0; k < 8; k++) vec[k] = 8'(k + 1);
    load_set(8, 1'b0, 1'b1);
    chk("s3_latency", lat, 32'd8);
    chk("s3_max",   {24'd0, MAX_DATA}, 32'd8);
    chk("s3_idx",   {29'd0, MAX_IDX},  32'd7);
    chk("s3_count", {28'd0, COUNT},    32'd8);
    // hold in RESULT with input traffic that must be ignored
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_DATA  = 8'hEE;
      IN_LAST  = 1'b1;
      @(posedge CLK);
      #1;
      chk("hold_out_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("hold_in_ready",  {31'd0, IN_READY},  32'd0);
      chk("hold_max",       {24'd0, MAX_DATA},  32'd8);
      chk("hold_idx",       {29'd0, MAX_IDX},   32'd7);
      chk("hold_count",     {28'd0, COUNT},     32'd8);
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    consume();

    // reset in the second SCAN cycle abandons the set
    vec[0] = 8'd2; vec[1] = 8'd7; vec[2] = 8'd1; vec[3] = 8'd3; vec[4] = 8'd5;
    load_set(5, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, IN_READY},  32'd1);
    chk("mid_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("mid_rst_count",     {28'd0, COUNT},     32'd0);
    chk("mid_rst_busy",      {31'd0, BUSY},      32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) begin
      @(posedge CLK);
      #1;
      chk("no_stale_valid", {31'd0, OUT_VALID}, 32'd0);
    end

    vec[0] = 8'hFF; vec[1] = 8'h80; vec[2] = 8'h7F;
    load_set(3, 1'b1, 1'b1);
    chk("s4_latency", lat, 32'd3);
    chk("s4_max",   {24'd0, MAX_DATA}, 32'hFF);
    chk("s4_idx",   {29'd0, MAX_IDX},  32'd0);
    chk("s4_count", {28'd0, COUNT},    32'd3);
    consume();

    vec[0] = 8'h04; vec[1] = 8'h10; vec[2] = 8'h30; vec[3] = 8'h30; vec[4] = 8'h2F;
    load_set(5, 1'b1, 1'b1);
    chk("s5_latency", lat, 32'd5);
    chk("s5_max",   {24'd0, MAX_DATA}, 32'h30);
    chk("s5_idx",   {29'd0, MAX_IDX},  32'd2);
    chk("s5_count", {28'd0, COUNT},    32'd5);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
